// File: rtl/pla_sop_eval_if.sv
// ---------------------------------------------------------------------------
// pla_sop_eval_if
//   Bundles the streaming input, streaming output and configuration-write
//   signals of pla_sop_eval.
//   master : the side that supplies vectors, consumes results, issues writes
//   slave  : the evaluator itself
// Signals:
//   in_valid/in_ready/in_data     input vector stream (N_IN literals)
//   out_valid/out_ready/out_data  result stream (N_OUT functions)
//   out_terms                     S2 term vector (only with PLA_TERMS_OUT_EN)
//   cfg_we/cfg_ready/cfg_addr/cfg_data  config write, held until cfg_ready
//   cfg_err                       sticky out-of-range write flag
// ---------------------------------------------------------------------------
interface pla_sop_eval_if #(
    parameter int N_IN    = 4,
    parameter int N_TERMS = 4,
    parameter int N_OUT   = 1,
    parameter int CFG_AW  = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [N_IN-1:0]     in_data;
    logic                out_valid;
    logic                out_ready;
    logic [N_OUT-1:0]    out_data;
`ifdef PLA_TERMS_OUT_EN
    logic [N_TERMS-1:0]  out_terms;
`endif
    logic                cfg_we;
    logic                cfg_ready;
    logic [CFG_AW-1:0]   cfg_addr;
    logic [2*N_IN-1:0]   cfg_data;
    logic                cfg_err;

    modport master (
        output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_data, cfg_ready, cfg_err
`ifdef PLA_TERMS_OUT_EN
        , out_terms
`endif
    );

    modport slave (
        input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, out_data, cfg_ready, cfg_err
`ifdef PLA_TERMS_OUT_EN
        , out_terms
`endif
    );
endinterface

// File: rtl/pla_sop_eval.sv
// ---------------------------------------------------------------------------
// pla_sop_eval
//   Runtime-programmable PLA: each input vector is matched against N_TERMS
//   product terms (care/polarity per literal); each of N_OUT outputs ORs a
//   programmable subset of the terms. Two-stage valid/ready pipeline
//   (S1 = term vector, S2 = OR results), one result per cycle.
//   Config writes go through IDLE -> DRAIN -> WRITE so that the pipeline
//   never mixes old and new configuration.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (restores default config)
//   io_bus  pla_sop_eval_if.slave (streams + config port)
// Optional build macro:
//   PLA_TERMS_OUT_EN  adds io_bus.out_terms, the term vector carried into S2
// ---------------------------------------------------------------------------
module pla_sop_eval #(
    parameter int N_IN    = 4,
    parameter int N_TERMS = 4,
    parameter int N_OUT   = 1,
    parameter int CFG_AW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pla_sop_eval_if.slave    io_bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_WRITE} state_t;

    // Defaults reproduce the legacy four-input SOP network:
    // x1'x2'x3' + x1'x3'x4 + x1x2x4' + x2x3 on output 0.
    localparam bit DFLT_OK = (N_IN >= 4) && (N_TERMS >= 4);

    function automatic logic [N_IN-1:0] dflt_care(input int k);
        logic [15:0] v;
        case (k)
            0:       v = 16'h0007;
            1:       v = 16'h000D;
            2:       v = 16'h000B;
            3:       v = 16'h0006;
            default: v = 16'h0000;
        endcase
        if (!DFLT_OK) v = 16'h0000;
        return v[N_IN-1:0];
    endfunction

    function automatic logic [N_IN-1:0] dflt_pol(input int k);
        logic [15:0] v;
        case (k)
            1:       v = 16'h0008;
            2:       v = 16'h0003;
            3:       v = 16'h0006;
            default: v = 16'h0000;
        endcase
        if (!DFLT_OK) v = 16'h0000;
        return v[N_IN-1:0];
    endfunction

    function automatic logic [N_TERMS-1:0] dflt_mask(input int j);
        logic [N_TERMS-1:0] m;
        for (int b = 0; b < N_TERMS; b++) m[b] = DFLT_OK && (j == 0) && (b < 4);
        return m;
    endfunction

    state_t              r_state;
    logic                r_cfg_ready;
    logic                r_cfg_err;
    logic                r_en;
    logic [N_IN-1:0]     r_care [N_TERMS];
    logic [N_IN-1:0]     r_pol  [N_TERMS];
    logic [N_TERMS-1:0]  r_mask [N_OUT];

    logic                r_vld_p1;
    logic                r_vld_p2;
    logic [N_TERMS-1:0]  r_terms_p1;
    logic [N_OUT-1:0]    r_out_p2;
`ifdef PLA_TERMS_OUT_EN
    logic [N_TERMS-1:0]  r_terms_p2;
`endif

    logic [N_TERMS-1:0]  w_terms_p0;
    logic [N_OUT-1:0]    w_or_p1;
    logic                w_s2_adv;
    logic                w_s1_open;
    logic                w_in_ready;
    logic                w_accept;
    int                  w_addr;
    logic                w_addr_ok;

    assign w_addr     = int'(io_bus.cfg_addr);
    assign w_addr_ok  = (w_addr < N_TERMS + N_OUT);
    assign w_s2_adv   = !r_vld_p2 || io_bus.out_ready;
    assign w_s1_open  = !r_vld_p1 || w_s2_adv;
    // cfg_we blocks inputs combinationally so a write wins over a same-cycle vector.
    assign w_in_ready = r_en && (r_state == ST_IDLE) && !io_bus.cfg_we && w_s1_open;
    assign w_accept   = io_bus.in_valid && w_in_ready;

    // A literal mismatches when it is cared about and differs from its polarity.
    always_comb begin
        w_terms_p0 = '0;
        for (int k = 0; k < N_TERMS; k++)
            w_terms_p0[k] = ~|(r_care[k] & (io_bus.in_data ^ r_pol[k]));
    end

    always_comb begin
        w_or_p1 = '0;
        for (int j = 0; j < N_OUT; j++)
            w_or_p1[j] = |(r_mask[j] & r_terms_p1);
    end

    // Config FSM and configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cfg_ready <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_en        <= 1'b0;
            for (int k = 0; k < N_TERMS; k++) begin
                r_care[k] <= dflt_care(k);
                r_pol[k]  <= dflt_pol(k);
            end
            for (int j = 0; j < N_OUT; j++) r_mask[j] <= dflt_mask(j);
        end else begin
            r_en <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.cfg_we) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!r_vld_p1 && !r_vld_p2) begin
                        r_state     <= ST_WRITE;
                        r_cfg_ready <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_state     <= ST_IDLE;
                    r_cfg_ready <= 1'b0;
                    if (!w_addr_ok) r_cfg_err <= 1'b1;
                    for (int k = 0; k < N_TERMS; k++)
                        if (w_addr == k) {r_care[k], r_pol[k]} <= io_bus.cfg_data;
                    for (int j = 0; j < N_OUT; j++)
                        if (w_addr == N_TERMS + j) r_mask[j] <= io_bus.cfg_data[N_TERMS-1:0];
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Stage S1: term vector
    always_ff @(posedge clk) begin
        if (w_accept) r_terms_p1 <= w_terms_p0;
    end

    // Stage S2: OR results (held while stalled)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1   <= 1'b0;
            r_vld_p2   <= 1'b0;
            r_out_p2   <= '0;
`ifdef PLA_TERMS_OUT_EN
            r_terms_p2 <= '0;
`endif
        end else begin
            if (w_s1_open) r_vld_p1 <= w_accept;
            if (w_s2_adv) begin
                r_vld_p2 <= r_vld_p1;
                if (r_vld_p1) begin
                    r_out_p2   <= w_or_p1;
`ifdef PLA_TERMS_OUT_EN
                    r_terms_p2 <= r_terms_p1;
`endif
                end
            end
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_vld_p2;
    assign io_bus.out_data  = r_out_p2;
    assign io_bus.cfg_ready = r_cfg_ready;
    assign io_bus.cfg_err   = r_cfg_err;
`ifdef PLA_TERMS_OUT_EN
    assign io_bus.out_terms = r_terms_p2;
`endif

endmodule

// File: tb/tb_pla_sop_eval.sv
module tb_pla_sop_eval;
    localparam int N_IN = 4, N_TERMS = 4, N_OUT = 1, CFG_AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pla_sop_eval_if #(.N_IN(N_IN), .N_TERMS(N_TERMS), .N_OUT(N_OUT), .CFG_AW(CFG_AW)) bus();

    pla_sop_eval #(.N_IN(N_IN), .N_TERMS(N_TERMS), .N_OUT(N_OUT), .CFG_AW(CFG_AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic exp; int acc_cyc; } item_t;
    item_t q[$];

    // Reference: terms as literal lists (care/pol), output as OR over masked terms.
    logic [3:0] m_care [4];
    logic [3:0] m_pol  [4];
    logic [3:0] m_mask;
    logic       m_err;
    // Default-config truth table from the legacy network: 1 at 0,3,6,7,8,A,E,F.
    logic [15:0] exp_tab = 16'hC5C9;
    bit use_table = 1'b0;
    bit chk_lat   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_care[0] = 4'b0111; m_pol[0] = 4'b0000;   // x1'x2'x3'
        m_care[1] = 4'b1101; m_pol[1] = 4'b1000;   // x1'x3'x4
        m_care[2] = 4'b1011; m_pol[2] = 4'b0011;   // x1 x2 x4'
        m_care[3] = 4'b0110; m_pol[3] = 4'b0110;   // x2 x3
        m_mask = 4'b1111;
        m_err  = 1'b0;
        q.delete();
    endtask

    function automatic logic model_out(input logic [3:0] x);
        bit hit;
        for (int k = 0; k < 4; k++) begin
            if (m_mask[k]) begin
                hit = 1'b1;
                for (int i = 0; i < 4; i++)
                    if (m_care[k][i] && (x[i] != m_pol[k][i])) hit = 1'b0;
                if (hit) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_write(input int addr, input logic [7:0] data);
        if (addr < 4) begin
            m_care[addr] = data[7:4];
            m_pol[addr]  = data[3:0];
        end else if (addr == 4) begin
            m_mask = data[3:0];
        end else begin
            m_err = 1'b1;
        end
    endtask

    // Scoreboard monitor, sampling at the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cfg_err", bus.cfg_err, m_err);
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", bus.out_valid, 0);
                end else begin
                    chk("out_data", bus.out_data, q[0].exp);
                    if (bus.out_ready) begin
                        if (chk_lat) chk("latency", cyc - q[0].acc_cyc, 2);
                        void'(q.pop_front());
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back('{exp: (use_table ? exp_tab[bus.in_data] : model_out(bus.in_data)),
                              acc_cyc: cyc});
            if (bus.cfg_we && bus.cfg_ready) model_write(int'(bus.cfg_addr), bus.cfg_data);
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [3:0] v);
        int n = 0;
        logic ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = bus.in_ready;
            n++;
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input int addr, input logic [7:0] data);
        int n = 0;
        logic seen = 1'b0;
        bus.out_ready = 1'b1;
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = CFG_AW'(addr);
        bus.cfg_data  = data;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            seen = bus.cfg_ready;
            if (!seen) chk("in_ready_blocked_by_cfg", bus.in_ready, 0);
        end
        if (!seen) chk("cfg_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        @(negedge clk);
        chk("cfg_ready_one_cycle", bus.cfg_ready, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        @(negedge clk);
        chk("idle_out_valid", bus.out_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic acc;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        model_reset();

        // Reset state
        #13;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_cfg_ready", bus.cfg_ready, 0);
        chk("rst_cfg_err", bus.cfg_err, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Default config, all 16 vectors back-to-back
        use_table = 1'b1; chk_lat = 1'b1; bus.out_ready = 1'b1;
        t0 = cyc;
        for (int v = 0; v < 16; v++) send(4'(v));
        chk("throughput", cyc - t0, 16);
        bus.in_valid = 1'b0;
        wait_drain();
        chk_lat = 1'b0;

        // Backpressure: 0x0, 0x3 fill the pipe, 0x9 waits
        bus.out_ready = 1'b0;
        send(4'h0);
        send(4'h3);
        bus.in_valid = 1'b1; bus.in_data = 4'h9;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_out_data", bus.out_data, 1);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(4'h9);
        bus.in_valid = 1'b0;
        wait_drain();
        use_table = 1'b0;

        // Config write with two vectors in flight
        send(4'h0);
        send(4'h6);
        bus.in_valid = 1'b0;
        cfg_write(4, 8'h01);
        send(4'h0);
        send(4'h6);
        bus.in_valid = 1'b0;
        wait_drain();

        // Out-of-range write
        cfg_write(15, 8'hFF);
        @(negedge clk);
        chk("cfg_err_set", bus.cfg_err, 1);
        @(posedge clk); #1;
        send(4'h0);
        send(4'h6);
        bus.in_valid = 1'b0;
        wait_drain();

        // Simultaneous input and config write: write goes first
        bus.in_valid = 1'b1; bus.in_data = 4'h7;
        cfg_write(4, 8'h0F);
        send(4'h7);
        bus.in_valid = 1'b0;
        wait_drain();

        // Random traffic with random backpressure and occasional writes
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc || !bus.in_valid) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = 4'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0)
                cfg_write(int'($urandom_range(0, 5)), 8'($urandom));
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        wait_drain();
        chk("cfg_err_sticky", bus.cfg_err, 1);

        // Reset mid-stream
        bus.out_ready = 1'b0;
        send(4'h0);
        send(4'h6);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_data", bus.out_data, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_cfg_err", bus.cfg_err, 0);
        bus.in_valid = 1'b0;
        model_reset();
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        use_table = 1'b1; bus.out_ready = 1'b1;
        for (int v = 0; v < 16; v++) send(4'(v));
        bus.in_valid = 1'b0;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
